// File: rtl/u_jump_ras.sv
// rtl/u_jump_ras.sv - registered J/JAL/JR/JALR resolution with a circular return-address stack
// Decode results land on the ID/EX boundary one cycle later; a stall freezes every register.
module u_jump_ras #(
    parameter int DATA_WIDTH   = 32,
    parameter int SIZEOP       = 6,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_valid,
    input  logic                             i_stall,
    input  logic [DATA_WIDTH-1:0]            i_currentpc,
    input  logic [DATA_WIDTH-1:0]            i_instruccion,
    input  logic [DATA_WIDTH-1:0]            i_regA,
    output logic                             o_valid,
    output logic                             o_jump,
    output logic [DATA_WIDTH-1:0]            o_pcjump,
    output logic [DATA_WIDTH-1:0]            o_return_address,
    output logic                             o_return,
    output logic                             o_rd_selector,
    output logic                             o_flush,
    output logic                             o_ras_hit,
    output logic [DATA_WIDTH-1:0]            o_ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   o_ras_count,
    output logic                             o_ras_full,
    output logic                             o_ras_empty,
    output logic                             o_ras_ovf,
    output logic                             o_ras_udf
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [SIZEOP-1:0] OP_SPECIAL = '0;
    localparam logic [SIZEOP-1:0] OP_J       = SIZEOP'(2);
    localparam logic [SIZEOP-1:0] OP_JAL     = SIZEOP'(3);
    localparam logic [SIZEOP-1:0] FN_JR      = SIZEOP'(8);
    localparam logic [SIZEOP-1:0] FN_JALR    = SIZEOP'(9);
    localparam logic [4:0]        REG_RA     = 5'd31;

    logic [DATA_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]         r_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic                  r_udf;
    logic [FW-1:0]         r_flush_cnt;

    logic                  r_valid;
    logic                  r_jump;
    logic [DATA_WIDTH-1:0] r_pcjump;
    logic [DATA_WIDTH-1:0] r_ret_addr;
    logic                  r_return;
    logic                  r_rd_sel;
    logic                  r_hit;

    logic [SIZEOP-1:0]     w_op;
    logic [SIZEOP-1:0]     w_funct;
    logic [4:0]            w_rs;
    logic                  w_is_j;
    logic                  w_is_jal;
    logic                  w_is_jr;
    logic                  w_is_jalr;
    logic                  w_jump;
    logic [DATA_WIDTH-1:0] w_link;
    logic [DATA_WIDTH-1:0] w_jtarget;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_empty;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_top;
    logic                  w_ras_push;
    logic                  w_ras_pop;
    logic                  w_ras_swap;
    logic                  w_hit;
    logic                  w_accept;
    logic [PW-1:0]         w_ptr_inc;
    logic [PW-1:0]         w_ptr_dec;

    assign w_op      = i_instruccion[DATA_WIDTH-1 -: SIZEOP];
    assign w_funct   = i_instruccion[SIZEOP-1:0];
    assign w_rs      = i_instruccion[25:21];

    assign w_is_j    = i_valid && (w_op == OP_J);
    assign w_is_jal  = i_valid && (w_op == OP_JAL);
    assign w_is_jr   = i_valid && (w_op == OP_SPECIAL) && (w_funct == FN_JR);
    assign w_is_jalr = i_valid && (w_op == OP_SPECIAL) && (w_funct == FN_JALR);
    assign w_jump    = w_is_j || w_is_jal || w_is_jr || w_is_jalr;

    assign w_link    = i_currentpc + DATA_WIDTH'(1);
    assign w_jtarget = i_currentpc + DATA_WIDTH'(i_instruccion[25:0]);
    assign w_target  = (w_is_j || w_is_jal)   ? w_jtarget :
                       (w_is_jr || w_is_jalr) ? i_regA    : '0;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(RAS_DEPTH));
    assign w_top     = w_empty ? '0 : r_ras[r_ptr];

    // JALR through r31 is a call from a return site: replace the top instead of growing
    assign w_ras_swap = w_is_jalr && (w_rs == REG_RA);
    assign w_ras_push = w_is_jal || (w_is_jalr && (w_rs != REG_RA));
    assign w_ras_pop  = w_is_jr && (w_rs == REG_RA);
    assign w_hit      = w_ras_pop && !w_empty && (w_top == i_regA);

    assign w_accept  = !i_stall;
    assign w_ptr_inc = r_ptr + PW'(1);
    assign w_ptr_dec = r_ptr - PW'(1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid    <= 1'b0;
            r_jump     <= 1'b0;
            r_pcjump   <= '0;
            r_ret_addr <= '0;
            r_return   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_hit      <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= i_valid;
            r_jump     <= w_jump;
            r_pcjump   <= w_target;
            r_ret_addr <= i_valid ? w_link : '0;
            r_return   <= w_is_jal || w_is_jalr;
            r_rd_sel   <= w_is_jal;
            r_hit      <= w_hit;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (w_accept) begin
            if (w_ras_swap) begin
                if (w_empty) begin
                    r_ptr            <= w_ptr_inc;
                    r_ras[w_ptr_inc] <= w_link;
                    r_count          <= CW'(1);
                    r_udf            <= 1'b1;
                end else begin
                    r_ras[r_ptr] <= w_link;
                end
            end else if (w_ras_push) begin
                // When full the slot after the top holds the oldest entry, so it is overwritten
                r_ptr            <= w_ptr_inc;
                r_ras[w_ptr_inc] <= w_link;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_ras_pop) begin
                if (w_empty) begin
                    r_udf <= 1'b1;
                end else begin
                    r_ptr   <= w_ptr_dec;
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_flush_cnt <= '0;
        end else if (w_accept) begin
            if (w_jump) begin
                r_flush_cnt <= FW'(FLUSH_CYCLES);
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - FW'(1);
            end
        end
    end

    assign o_valid          = r_valid;
    assign o_jump           = r_jump;
    assign o_pcjump         = r_pcjump;
    assign o_return_address = r_ret_addr;
    assign o_return         = r_return;
    assign o_rd_selector    = r_rd_sel;
    assign o_flush          = (r_flush_cnt != '0);
    assign o_ras_hit        = r_hit;
    assign o_ras_top        = w_top;
    assign o_ras_count      = r_count;
    assign o_ras_full       = w_full;
    assign o_ras_empty      = w_empty;
    assign o_ras_ovf        = r_ovf;
    assign o_ras_udf        = r_udf;

endmodule

// File: tb/tb_u_jump_ras.sv
// tb/tb_u_jump_ras.sv - scoreboard bench for u_jump_ras against a queue-based reference model
module tb_u_jump_ras;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int FC    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_stall = 1'b0;
    logic [DW-1:0] i_pc = '0;
    logic [DW-1:0] i_instr = '0;
    logic [DW-1:0] i_rega = '0;

    logic          o_valid, o_jump, o_return, o_rd_selector, o_flush, o_ras_hit;
    logic [DW-1:0] o_pcjump, o_return_address, o_ras_top;
    logic [CW-1:0] o_ras_count;
    logic          o_ras_full, o_ras_empty, o_ras_ovf, o_ras_udf;

    u_jump_ras #(.DATA_WIDTH(DW), .SIZEOP(6), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid), .i_stall(i_stall),
        .i_currentpc(i_pc), .i_instruccion(i_instr), .i_regA(i_rega),
        .o_valid(o_valid), .o_jump(o_jump), .o_pcjump(o_pcjump),
        .o_return_address(o_return_address), .o_return(o_return),
        .o_rd_selector(o_rd_selector), .o_flush(o_flush), .o_ras_hit(o_ras_hit),
        .o_ras_top(o_ras_top), .o_ras_count(o_ras_count), .o_ras_full(o_ras_full),
        .o_ras_empty(o_ras_empty), .o_ras_ovf(o_ras_ovf), .o_ras_udf(o_ras_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v, j, ret, rds, fl, hit, full, empty, ovf, udf;
        bit [31:0] pcj, ra, top;
        int        cnt;
    } exp_t;

    exp_t      sb[$];
    exp_t      last;
    bit [31:0] ras_m[$];
    bit        m_ovf, m_udf;
    int        m_flush;
    int        total = 0;
    int        bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic bit [31:0] mk_j(input bit [5:0] op, input bit [25:0] imm);
        return {op, imm};
    endfunction

    function automatic bit [31:0] mk_r(input bit [4:0] rs, input bit [4:0] rd, input bit [5:0] fn);
        return {6'd0, rs, 5'd0, rd, 5'd0, fn};
    endfunction

    task automatic model_reset();
        ras_m.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_flush = 0;
        last    = '{default: 0};
    endtask

    function automatic void fill_ras(ref exp_t e);
        e.fl    = (m_flush != 0);
        e.cnt   = ras_m.size();
        e.top   = (ras_m.size() > 0) ? ras_m[ras_m.size()-1] : 32'd0;
        e.full  = (ras_m.size() == DEPTH);
        e.empty = (ras_m.size() == 0);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
    endfunction

    task automatic ras_push(input bit [31:0] val);
        if (ras_m.size() == DEPTH) begin
            void'(ras_m.pop_front());
            m_ovf = 1'b1;
        end
        ras_m.push_back(val);
    endtask

    task automatic step(input bit v, input bit s, input bit [31:0] pc,
                        input bit [31:0] ins, input bit [31:0] ra);
        exp_t     e;
        bit [5:0] op, fn;
        bit [4:0] rs;
        bit       isj, isjal, isjr, isjalr;
        @(negedge clk);
        i_valid = v; i_stall = s; i_pc = pc; i_instr = ins; i_rega = ra;
        if (s) begin
            sb.push_back(last);
            return;
        end
        e = '{default: 0};
        op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21];
        isj    = v && op == 6'd2;
        isjal  = v && op == 6'd3;
        isjr   = v && op == 6'd0 && fn == 6'd8;
        isjalr = v && op == 6'd0 && fn == 6'd9;
        if (v) begin
            e.v  = 1'b1;
            e.ra = pc + 32'd1;
        end
        if (isj || isjal) begin
            e.j   = 1'b1;
            e.pcj = pc + {6'd0, ins[25:0]};
        end
        if (isjr || isjalr) begin
            e.j   = 1'b1;
            e.pcj = ra;
        end
        e.ret = isjal || isjalr;
        e.rds = isjal;
        if (isjal || (isjalr && rs != 5'd31)) begin
            ras_push(pc + 32'd1);
        end else if (isjalr) begin
            if (ras_m.size() == 0) begin
                m_udf = 1'b1;
            end else begin
                void'(ras_m.pop_back());
            end
            ras_m.push_back(pc + 32'd1);
        end else if (isjr && rs == 5'd31) begin
            if (ras_m.size() == 0) begin
                m_udf = 1'b1;
            end else begin
                e.hit = (ras_m[ras_m.size()-1] == ra);
                void'(ras_m.pop_back());
            end
        end
        if (e.j) m_flush = FC;
        else if (m_flush > 0) m_flush--;
        fill_ras(e);
        last = e;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid", o_valid, e.v);
                chk("jump", o_jump, e.j);
                chk("pcjump", o_pcjump, e.pcj);
                chk("ret_addr", o_return_address, e.ra);
                chk("return", o_return, e.ret);
                chk("rd_sel", o_rd_selector, e.rds);
                chk("flush", o_flush, e.fl);
                chk("ras_hit", o_ras_hit, e.hit);
                chk("ras_top", o_ras_top, e.top);
                chk("ras_count", o_ras_count, e.cnt);
                chk("ras_full", o_ras_full, e.full);
                chk("ras_empty", o_ras_empty, e.empty);
                chk("ras_ovf", o_ras_ovf, e.ovf);
                chk("ras_udf", o_ras_udf, e.udf);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_jump"}, o_jump, 0);
        chk({tag, "_pcjump"}, o_pcjump, 0);
        chk({tag, "_return"}, o_return, 0);
        chk({tag, "_flush"}, o_flush, 0);
        chk({tag, "_count"}, o_ras_count, 0);
        chk({tag, "_top"}, o_ras_top, 0);
        chk({tag, "_empty"}, o_ras_empty, 1);
        chk({tag, "_full"}, o_ras_full, 0);
        chk({tag, "_ovf"}, o_ras_ovf, 0);
        chk({tag, "_udf"}, o_ras_udf, 0);
    endtask

    initial begin : stimulus
        bit [31:0] ins, ra, pc;
        int        kind;
        model_reset();
        #2;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 0, 32'h10, 32'h0800_0020, 32'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 32'h100, mk_j(6'd3, 26'h55), 32'h0);
        step(1, 0, 32'h104, 32'h03E0_0008, 32'h101);
        for (int i = 0; i < 5; i++) step(1, 0, i, mk_j(6'd3, 26'h40), 32'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 32'h80 + i, 32'h03E0_0008, 32'd5 - i);
        step(1, 0, 32'h20, mk_r(5'd5, 5'd7, 6'd9), 32'h400);
        step(1, 0, 32'h30, mk_r(5'd31, 5'd7, 6'd9), 32'h500);
        for (int i = 0; i < 3; i++) step(1, 1, 32'h200, mk_j(6'd3, 26'h8), 32'h0);
        step(1, 0, 32'h200, mk_j(6'd3, 26'h8), 32'h0);
        step(1, 0, 32'h210, 32'h1234_5678, 32'h0);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        model_reset();
        #1;
        rst_n = 1'b1;

        step(1, 0, 32'h30, mk_r(5'd31, 5'd7, 6'd9), 32'h44);
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 7);
            pc   = $urandom;
            ra   = $urandom;
            case (kind)
                0: ins = mk_j(6'd2, 26'($urandom));
                1, 2: ins = mk_j(6'd3, 26'($urandom));
                3: begin
                    ins = mk_r(5'd31, 5'd0, 6'd8);
                    if (ras_m.size() > 0 && $urandom_range(0, 3) != 0) ra = ras_m[ras_m.size()-1];
                end
                4: ins = mk_r(5'($urandom_range(0, 30)), 5'd0, 6'd8);
                5: ins = mk_r(5'd31, 5'($urandom), 6'd9);
                6: ins = mk_r(5'($urandom_range(0, 30)), 5'($urandom), 6'd9);
                default: ins = $urandom;
            endcase
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, pc, ins, ra);
        end
        step(0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
